pdc_upd_sched: RTL

PDC_UPD_SCHED -- requirements
Module: pdc_upd_sched

---
 rtl/pdc_pkg.sv | 29 ++
 rtl/upd_fifo.sv | 59 +++++
 rtl/pdc_upd_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pdc_pkg.sv
// pdc_pkg: shared constants for the predictor update scheduler.
// Branch-kind codes, FSM state encoding and the queued update record width.
package pdc_pkg;

  localparam int PC_W   = 30;
  localparam int KIND_W = 3;

  localparam logic [KIND_W-1:0] NOT_JUMP      = 3'd0;
  localparam logic [KIND_W-1:0] DIRECT_JUMP   = 3'd1;
  localparam logic [KIND_W-1:0] RET           = 3'd4;
  localparam logic [KIND_W-1:0] INDIRECT_JUMP = 3'd5;
  localparam logic [KIND_W-1:0] CALL          = 3'd6;
  localparam logic [KIND_W-1:0] JUMP          = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2,
    CLEAR = 2'd3
  } sched_state_e;

  // Record = {tag, pc, npc, kind, taken, bh}: 1 + 30 + 30 + 3 + 1 = 65 fixed bits.
  localparam int REC_BASE_W = 65;

  function automatic int upd_rec_w(input int bh_w);
    return REC_BASE_W + bh_w;
  endfunction

endpackage

// File: rtl/upd_fifo.sv
// upd_fifo: synchronous FIFO of resolved-branch update records with occupancy count.
// Synchronous active-low reset; i_flush empties the queue in one cycle.
module upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_din,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dout,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // Full/empty protection: a push into a full queue or a pop of an empty one is ignored.
  assign w_push  = i_push && (r_count != CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign o_dout  = r_mem[r_rd];
  assign o_count = r_count;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Storage array; no reset needed, occupancy is tracked by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_din;
  end

  // Pointers and count; push+pop together leave the count unchanged.
  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pdc_upd_sched.sv
// pdc_upd_sched: schedules branch-predictor table updates onto the single table
// port shared with fetch lookups. Updates queue while fetch owns the port; a
// starved or full queue forces one write by stalling fetch. clr sweeps the table.
// Optional feature macro: PDC_UPD_BYPASS_EN (zero-latency write from IDLE).
module pdc_upd_sched
  import pdc_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int bh_width   = 14,
  parameter int STARVE_MAX = 8,
  parameter int IDX_W      = 10
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                upd_valid,
  input  logic [PC_W-1:0]     upd_pc,
  input  logic [PC_W-1:0]     upd_npc,
  input  logic [KIND_W-1:0]   upd_kind,
  input  logic                upd_taken,
  input  logic [bh_width-1:0] upd_bh,
  output logic                upd_ready,
  input  logic                lk_req,
  output logic                lk_stall,
  input  logic                clr,
  output logic                wr_en,
  output logic [PC_W-1:0]     wr_pc,
  output logic [PC_W-1:0]     wr_npc,
  output logic [KIND_W-1:0]   wr_kind,
  output logic                wr_taken,
  output logic [bh_width-1:0] wr_bh,
  output logic                wr_clr,
  output logic [IDX_W-1:0]    wr_idx,
  output logic                busy
);

  localparam int REC_W = upd_rec_w(bh_width);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int SW    = $clog2(STARVE_MAX + 1);

  sched_state_e        r_state;
  sched_state_e        w_state_nxt;
  logic [SW-1:0]       r_starve;
  logic [SW-1:0]       w_starve_nxt;
  logic [IDX_W-1:0]    r_wr_idx;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_count_nxt;
  logic [REC_W-1:0]    w_in_rec;
  logic [REC_W-1:0]    w_head_rec;
  logic                w_head_tag;
  logic [PC_W-1:0]     w_head_pc;
  logic [PC_W-1:0]     w_head_npc;
  logic [KIND_W-1:0]   w_head_kind;
  logic                w_head_taken;
  logic [bh_width-1:0] w_head_bh;
  logic                w_accept;
  logic                w_queueable;
  logic                w_bypass;
  logic                w_push;
  logic                w_pop;

  // Tag bit is set on every enqueued record so a drain only fires on a real entry.
  assign w_in_rec = {1'b1, upd_pc, upd_npc, upd_kind, upd_taken, upd_bh};
  assign {w_head_tag, w_head_pc, w_head_npc, w_head_kind, w_head_taken, w_head_bh} = w_head_rec;

  assign upd_ready   = (w_count < CW'(DEPTH)) && (r_state != CLEAR) && !clr;
  assign w_accept    = upd_valid && upd_ready;
  // Not-taken non-branches carry no training information and are dropped.
  assign w_queueable = !((upd_kind == NOT_JUMP) && !upd_taken);

`ifdef PDC_UPD_BYPASS_EN
  assign w_bypass = w_accept && w_queueable && (r_state == IDLE) && !lk_req;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_accept && w_queueable && !w_bypass;
  // Head drains when fetch leaves the port free, or unconditionally in FORCE.
  assign w_pop  = !clr && w_head_tag &&
                  (((r_state == PEND) && !lk_req) || (r_state == FORCE));

  upd_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .i_clk   (clk),
    .i_rstn  (rstn),
    .i_flush (clr),
    .i_push  (w_push),
    .i_din   (w_in_rec),
    .i_pop   (w_pop),
    .o_dout  (w_head_rec),
    .o_count (w_count)
  );

  // Occupancy after this cycle, used to decide whether the queue empties.
  always_comb begin
    w_count_nxt = w_count;
    if (w_push && !w_pop)      w_count_nxt = w_count + CW'(1);
    else if (!w_push && w_pop) w_count_nxt = w_count - CW'(1);
  end

  // Next-state, starvation counter and per-state port-arbitration outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    lk_stall     = 1'b0;
    wr_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        w_starve_nxt = '0;
        if (w_push) w_state_nxt = PEND;
      end
      PEND: begin
        if (!lk_req) begin
          w_starve_nxt = '0;
          if (w_count_nxt == '0) w_state_nxt = IDLE;
        end else begin
          w_starve_nxt = r_starve + SW'(1);
          if ((w_starve_nxt == SW'(STARVE_MAX)) || (w_count == CW'(DEPTH)))
            w_state_nxt = FORCE;
        end
      end
      FORCE: begin
        lk_stall     = 1'b1;
        w_starve_nxt = '0;
        w_state_nxt  = (w_count_nxt == '0) ? IDLE : PEND;
      end
      CLEAR: begin
        lk_stall = 1'b1;
        wr_clr   = 1'b1;
        if (r_wr_idx == '1) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (clr) begin
      w_state_nxt  = CLEAR;
      w_starve_nxt = '0;
    end
  end

  // State, starvation counter and clear-sweep index registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_starve <= '0;
      r_wr_idx <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      if (clr)                    r_wr_idx <= '0;
      else if (r_state == CLEAR)  r_wr_idx <= r_wr_idx + IDX_W'(1);
    end
  end

  assign wr_en  = w_pop || w_bypass;
  assign wr_idx = r_wr_idx;
  assign busy   = (r_state != IDLE);

  // Write payload: bypassed input, else queue head, else zero when idle.
  always_comb begin
    wr_pc    = '0;
    wr_npc   = '0;
    wr_kind  = '0;
    wr_taken = 1'b0;
    wr_bh    = '0;
    if (w_bypass) begin
      wr_pc    = upd_pc;
      wr_npc   = upd_npc;
      wr_kind  = upd_kind;
      wr_taken = upd_taken;
      wr_bh    = upd_bh;
    end else if (w_pop) begin
      wr_pc    = w_head_pc;
      wr_npc   = w_head_npc;
      wr_kind  = w_head_kind;
      wr_taken = w_head_taken;
      wr_bh    = w_head_bh;
    end
  end

endmodule
